// File: rtl/lsu_mem_ctrl.sv
// Multi-cycle load/store unit: sizes, aligns and traps core accesses, then
// drives a valid/ready data-memory port with variable read latency and a bus timeout.
module lsu_mem_ctrl #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [2:0]        i_req_funct3,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_rsp_valid,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_trap,
  output logic [2:0]        o_rsp_cause,
  output logic              o_busy,
  output logic              o_mem_valid,
  input  logic              i_mem_ready,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_ren,
  output logic              o_mem_wen,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_mask,
  input  logic              i_mem_rvalid,
  input  logic [31:0]       i_mem_rdata
);

  localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  localparam logic [2:0] CAUSE_NONE    = 3'd0;
  localparam logic [2:0] CAUSE_LD_MIS  = 3'd1;
  localparam logic [2:0] CAUSE_ST_MIS  = 3'd2;
  localparam logic [2:0] CAUSE_TIMEOUT = 3'd3;
  localparam logic [2:0] CAUSE_ILLEGAL = 3'd4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rword_q, rword_d;
  logic [2:0]        cause_q, cause_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              reqIllegal, reqMisaligned;
  logic [1:0]        offset;
  logic [3:0]        laneMask;
  logic [31:0]       shiftedRdata, loadData;

  // funct3[1:0] is the access size (0 byte, 1 half, 2 word); bit 2 selects zero extension.
  assign reqIllegal    = (i_req_funct3 == 3'b011) || (i_req_funct3[2:1] == 2'b11) ||
                         (i_req_we && i_req_funct3[2]);
  assign reqMisaligned = ((i_req_funct3[1:0] == 2'b01) && i_req_addr[0]) ||
                         ((i_req_funct3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00));

  assign offset       = addr_q[1:0];
  assign shiftedRdata = rword_q >> {offset, 3'b000};

  always_comb begin
    laneMask = 4'b1111;
    loadData = shiftedRdata;
    case (funct3_q[1:0])
      2'b00:   laneMask = 4'b0001 << offset;
      2'b01:   laneMask = offset[1] ? 4'b1100 : 4'b0011;
      default: laneMask = 4'b1111;
    endcase
    case (funct3_q)
      3'b000:  loadData = {{24{shiftedRdata[7]}}, shiftedRdata[7:0]};
      3'b001:  loadData = {{16{shiftedRdata[15]}}, shiftedRdata[15:0]};
      3'b100:  loadData = {24'd0, shiftedRdata[7:0]};
      3'b101:  loadData = {16'd0, shiftedRdata[15:0]};
      default: loadData = shiftedRdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rword_d     = rword_q;
    cause_d     = cause_q;
    cnt_d       = cnt_q;
    o_req_ready = 1'b0;
    o_busy      = 1'b1;
    o_rsp_valid = 1'b0;
    o_rsp_rdata = '0;
    o_rsp_trap  = 1'b0;
    o_rsp_cause = CAUSE_NONE;
    o_mem_valid = 1'b0;
    o_mem_addr  = '0;
    o_mem_ren   = 1'b0;
    o_mem_wen   = 1'b0;
    o_mem_wdata = '0;
    o_mem_mask  = '0;

    case (state_q)
      IDLE: begin
        o_req_ready = 1'b1;
        o_busy      = 1'b0;
        if (i_req_valid) begin
          we_d     = i_req_we;
          funct3_d = i_req_funct3;
          addr_d   = i_req_addr;
          wdata_d  = i_req_wdata;
          cnt_d    = '0;
          cause_d  = CAUSE_NONE;
          if (reqIllegal) begin
            cause_d = CAUSE_ILLEGAL;
            state_d = DONE;
          end else if (reqMisaligned) begin
            cause_d = i_req_we ? CAUSE_ST_MIS : CAUSE_LD_MIS;
            state_d = DONE;
          end else begin
            state_d = ISSUE;
          end
        end
      end

      ISSUE: begin
        o_mem_valid = 1'b1;
        o_mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
        o_mem_ren   = ~we_q;
        o_mem_wen   = we_q;
        o_mem_wdata = wdata_q << {offset, 3'b000};
        o_mem_mask  = laneMask;
        if (i_mem_ready) begin
          if (we_q) begin
            state_d = DONE;
          end else if (i_mem_rvalid) begin
            rword_d = i_mem_rdata;
            state_d = DONE;
          end else begin
            state_d = WAIT;
          end
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TO_LAST))) begin
          cause_d = CAUSE_TIMEOUT;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // An accepted read must complete, so there is no timeout here.
      WAIT: begin
        if (i_mem_rvalid) begin
          rword_d = i_mem_rdata;
          state_d = DONE;
        end
      end

      DONE: begin
        o_rsp_valid = 1'b1;
        o_rsp_trap  = (cause_q != CAUSE_NONE);
        o_rsp_cause = cause_q;
        o_rsp_rdata = (!we_q && (cause_q == CAUSE_NONE)) ? loadData : 32'd0;
        state_d     = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rword_q  <= '0;
      cause_q  <= CAUSE_NONE;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rword_q  <= rword_d;
      cause_q  <= cause_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
